// File: rtl/axil_write_master_if.sv
// Signal bundle between a local write initiator and an AXI4-Lite write slave,
// including the local command/response side and the status counters.
interface axil_write_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [STRB_WIDTH-1:0] cmd_strb;

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  logic                  rsp_valid;
  logic [1:0]            rsp_resp;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  done_count;
  logic [CNT_WIDTH-1:0]  err_count;

  modport master (
    input  cmd_valid, cmd_addr, cmd_data, cmd_strb,
    input  awready, wready, bvalid, bresp,
    output cmd_ready, awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output rsp_valid, rsp_resp, busy, done_count, err_count
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_data, cmd_strb,
    output awready, wready, bvalid, bresp,
    input  cmd_ready, awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  rsp_valid, rsp_resp, busy, done_count, err_count
  );
endinterface

// File: rtl/axil_write_master.sv
// AXI4-Lite write initiator: one outstanding single-beat write at a time,
// B response returned locally, with wrapping completion and saturating error counters.
module axil_write_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                areset,
  axil_write_master_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_width_check
    $error("axil_write_master: DATA_WIDTH must be 32 or 64");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ADDR_DATA = 2'd1,
    S_RESP      = 2'd2
  } state_e;

  state_e                state_q;
  logic                  cmd_ready_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  rsp_valid_q;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [1:0]            rsp_resp_q;
  logic [CNT_WIDTH-1:0]  done_q;
  logic [CNT_WIDTH-1:0]  err_q;

  logic                  aw_pend_d;
  logic                  w_pend_d;
  logic [CNT_WIDTH-1:0]  done_d;
  logic [CNT_WIDTH-1:0]  err_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Each channel stays pending until its own handshake; the two are independent.
  always_comb begin
    aw_pend_d = awvalid_q && !bus.awready;
    w_pend_d  = wvalid_q && !bus.wready;
    done_d    = done_q + CNT_WIDTH'(1);
    err_d     = bus.bresp[1] ? sat_inc(err_q) : err_q;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_resp_q  <= 2'b00;
      done_q      <= '0;
      err_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            awaddr_q    <= bus.cmd_addr;
            wdata_q     <= bus.cmd_data;
            wstrb_q     <= bus.cmd_strb;
            awvalid_q   <= 1'b1;
            wvalid_q    <= 1'b1;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= S_ADDR_DATA;
          end
        end
        S_ADDR_DATA: begin
          awvalid_q <= aw_pend_d;
          wvalid_q  <= w_pend_d;
          if (!aw_pend_d && !w_pend_d) begin
            bready_q <= 1'b1;
            state_q  <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.bvalid) begin
            rsp_resp_q  <= bus.bresp;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b0;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.awvalid    = awvalid_q;
  assign bus.awaddr     = awaddr_q;
  assign bus.awprot     = 3'b000;
  assign bus.wvalid     = wvalid_q;
  assign bus.wdata      = wdata_q;
  assign bus.wstrb      = wstrb_q;
  assign bus.bready     = bready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_resp   = rsp_resp_q;
  assign bus.busy       = busy_q;
  assign bus.done_count = done_q;
  assign bus.err_count  = err_q;
endmodule

// File: tb/tb_axil_write_master.sv
// Bench for axil_write_master: transaction-level reference model checked every cycle,
// a configurable-latency AXI4-Lite slave with a small register file, and directed scenarios.
module tb_axil_write_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk    = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  axil_write_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(16)) bus ();
  axil_write_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2))  bus2 ();

  axil_write_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .areset(areset), .bus(bus));
  axil_write_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .areset(areset), .bus(bus2));

  // The narrow-counter instance sees exactly the same stimulus.
  assign bus2.cmd_valid = bus.cmd_valid;
  assign bus2.cmd_addr  = bus.cmd_addr;
  assign bus2.cmd_data  = bus.cmd_data;
  assign bus2.cmd_strb  = bus.cmd_strb;
  assign bus2.awready   = bus.awready;
  assign bus2.wready    = bus.wready;
  assign bus2.bvalid    = bus.bvalid;
  assign bus2.bresp     = bus.bresp;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is either absent, offering AW and/or W,
  // or waiting on B; counters are unbounded integers reduced at compare time.
  bit          m_tx, m_aw, m_w, m_b, m_rdy, m_rsp;
  bit [1:0]    m_resp;
  bit [AW-1:0] m_addr;
  bit [DW-1:0] m_data;
  bit [SW-1:0] m_strb;
  int unsigned m_done, m_err;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      m_tx <= 0; m_aw <= 0; m_w <= 0; m_b <= 0; m_rdy <= 0; m_rsp <= 0;
      m_resp <= 0; m_addr <= 0; m_data <= 0; m_strb <= 0;
      m_done <= 0; m_err <= 0;
    end else begin
      m_rsp <= 0;
      if (!m_tx) begin
        if (m_rdy && bus.cmd_valid) begin
          m_tx <= 1; m_aw <= 1; m_w <= 1; m_rdy <= 0;
          m_addr <= bus.cmd_addr; m_data <= bus.cmd_data; m_strb <= bus.cmd_strb;
        end else begin
          m_rdy <= 1;
        end
      end else if (m_aw || m_w) begin
        m_aw <= m_aw && !bus.awready;
        m_w  <= m_w && !bus.wready;
        m_b  <= !(m_aw && !bus.awready) && !(m_w && !bus.wready);
      end else if (bus.bvalid) begin
        m_tx <= 0; m_b <= 0; m_rsp <= 1; m_rdy <= 1;
        m_resp <= bus.bresp;
        m_done <= m_done + 1;
        m_err  <= m_err + (bus.bresp[1] ? 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready",  64'(bus.cmd_ready),  64'(m_rdy));
    chk("awvalid",    64'(bus.awvalid),    64'(m_aw));
    chk("wvalid",     64'(bus.wvalid),     64'(m_w));
    chk("bready",     64'(bus.bready),     64'(m_b));
    chk("rsp_valid",  64'(bus.rsp_valid),  64'(m_rsp));
    chk("busy",       64'(bus.busy),       64'(m_tx));
    chk("rsp_resp",   64'(bus.rsp_resp),   64'(m_resp));
    chk("awaddr",     64'(bus.awaddr),     64'(m_addr));
    chk("wdata",      64'(bus.wdata),      64'(m_data));
    chk("wstrb",      64'(bus.wstrb),      64'(m_strb));
    chk("awprot",     64'(bus.awprot),     64'(0));
    chk("done_count", 64'(bus.done_count), 64'(m_done % 32'd65536));
    chk("err_count",  64'(bus.err_count),  64'((m_err > 32'd65535) ? 32'd65535 : m_err));
    chk("n_done",     64'(bus2.done_count), 64'(m_done % 32'd4));
    chk("n_err",      64'(bus2.err_count),  64'((m_err > 32'd3) ? 32'd3 : m_err));
    chk("n_rsp",      64'(bus2.rsp_valid),  64'(m_rsp));
    chk("n_bready",   64'(bus2.bready),     64'(m_b));
  end

  // Slave side: ready after a configurable number of cycles of valid,
  // bvalid a configurable number of cycles after both AW and W landed.
  int          aw_lat, w_lat, b_lat;
  int          aw_age, w_age, b_age;
  bit          got_aw, got_w, b_pend, spur_b;
  bit [1:0]    resp_q[$];
  bit [DW-1:0] mem [bit [AW-1:0]];
  bit [AW-1:0] lat_addr;
  bit [DW-1:0] lat_data;
  bit [SW-1:0] lat_strb;
  bit          hs_cmd_last;
  int          cyc, accepts;

  task automatic slave_clear();
    aw_age = 0; w_age = 0; b_age = 0;
    got_aw = 0; got_w = 0; b_pend = 0; spur_b = 0;
    resp_q.delete();
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 2'b00;
  endtask

  task automatic tick();
    bit hs_aw, hs_w, hs_b, pv_aw, pv_w;
    hs_aw = bus.awvalid && bus.awready;
    hs_w  = bus.wvalid && bus.wready;
    hs_b  = bus.bvalid && bus.bready;
    pv_aw = bus.awvalid && !bus.awready;
    pv_w  = bus.wvalid && !bus.wready;
    hs_cmd_last = bus.cmd_valid && bus.cmd_ready;
    if (hs_aw) lat_addr = bus.awaddr;
    if (hs_w) begin lat_data = bus.wdata; lat_strb = bus.wstrb; end
    @(posedge clk); #1;
    cyc++;
    if (hs_cmd_last) accepts++;
    aw_age = pv_aw ? aw_age + 1 : 0;
    w_age  = pv_w  ? w_age + 1  : 0;
    if (hs_aw) got_aw = 1;
    if (hs_w)  got_w = 1;
    if (hs_b) begin
      b_pend = 0;
      if (resp_q.size() > 0) void'(resp_q.pop_front());
    end
    if (got_aw && got_w) begin
      for (int i = 0; i < SW; i++)
        if (lat_strb[i]) mem[lat_addr][8*i +: 8] = lat_data[8*i +: 8];
      got_aw = 0; got_w = 0; b_pend = 1; b_age = 0;
    end else if (b_pend) begin
      b_age++;
    end
    bus.awready = bus.awvalid && (aw_age >= aw_lat);
    bus.wready  = bus.wvalid && (w_age >= w_lat);
    bus.bvalid  = (b_pend && (b_age >= b_lat)) || spur_b;
    bus.bresp   = spur_b ? 2'b10 : ((resp_q.size() > 0) ? resp_q[0] : 2'b00);
  endtask

  task automatic do_reset();
    areset = 1; bus.cmd_valid = 0; slave_clear();
    repeat (2) tick();
    areset = 0;
    tick();
  endtask

  task automatic send(input bit [AW-1:0] a, input bit [DW-1:0] d, input bit [SW-1:0] s);
    int n;
    bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_strb = s; bus.cmd_valid = 1;
    n = 0;
    do begin tick(); n++; end while (!hs_cmd_last && n < 20);
    bus.cmd_valid = 0;
    chk("cmd_accept", 64'(hs_cmd_last), 64'(1));
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin tick(); n++; end
    chk("rsp_arrives", 64'(bus.rsp_valid), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_acc;
    bus.cmd_valid = 0; bus.cmd_addr = 0; bus.cmd_data = 0; bus.cmd_strb = 0;
    slave_clear();
    cyc = 0; accepts = 0;
    aw_lat = 0; w_lat = 0; b_lat = 0;

    // Reset state
    tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    chk("rst_busy",      64'(bus.busy),      64'(0));
    chk("rst_done",      64'(bus.done_count), 64'(0));
    do_reset();
    chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));

    // Zero-wait slave
    resp_q = '{2'b00};
    send(32'h10, 32'hDEADBEEF, 4'hF);
    chk("zw_awvalid_c1", 64'(bus.awvalid), 64'(1));
    chk("zw_wvalid_c1",  64'(bus.wvalid),  64'(1));
    chk("zw_awaddr_c1",  64'(bus.awaddr),  64'h10);
    chk("zw_wdata_c1",   64'(bus.wdata),   64'hDEADBEEF);
    tick();
    chk("zw_bready_c2",  64'(bus.bready),  64'(1));
    tick();
    chk("zw_rsp_c3",     64'(bus.rsp_valid), 64'(1));
    chk("zw_resp_c3",    64'(bus.rsp_resp),  64'(0));
    chk("zw_done_c3",    64'(bus.done_count), 64'(1));
    chk("zw_busy_c3",    64'(bus.busy),      64'(0));
    tick();
    chk("zw_rsp_c4",     64'(bus.rsp_valid), 64'(0));

    // Skewed ready: AW in cycle 1, W in cycle 4
    w_lat = 3; resp_q = '{2'b00};
    send(32'h20, 32'h01234567, 4'hF);
    tick();
    chk("sk_awvalid_c2", 64'(bus.awvalid), 64'(0));
    chk("sk_wvalid_c2",  64'(bus.wvalid),  64'(1));
    repeat (2) tick();
    chk("sk_wvalid_c4",  64'(bus.wvalid),  64'(1));
    chk("sk_bready_c4",  64'(bus.bready),  64'(0));
    tick();
    chk("sk_bready_c5",  64'(bus.bready),  64'(1));
    wait_rsp();
    chk("sk_done",       64'(bus.done_count), 64'(2));

    // Register-file style slave, three back-to-back writes
    do_reset();
    mem.delete();
    aw_lat = 1; w_lat = 1; b_lat = 0; resp_q = '{2'b00, 2'b00, 2'b00};
    send(32'h100, 32'h11112222, 4'hF); wait_rsp();
    send(32'h104, 32'h33334444, 4'hF); wait_rsp();
    send(32'h100, 32'hAAAABBBB, 4'h3); wait_rsp();
    chk("rf_done",    64'(bus.done_count), 64'(3));
    chk("rf_err",     64'(bus.err_count),  64'(0));
    chk("rf_mem100",  64'(mem[32'h100]),   64'h1111BBBB);
    chk("rf_mem104",  64'(mem[32'h104]),   64'h33334444);

    // Error responses
    do_reset();
    aw_lat = 0; w_lat = 0; resp_q = '{2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 3; i++) begin send(32'h40 + 32'(4*i), 32'hC0DE0000 + 32'(i), 4'hF); wait_rsp(); end
    chk("er_err",    64'(bus.err_count),  64'(2));
    chk("er_done",   64'(bus.done_count), 64'(3));
    do_reset();
    resp_q = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    for (int i = 0; i < 5; i++) begin send(32'h80, 32'(i), 4'h1); wait_rsp(); end
    chk("sat_n_err",  64'(bus2.err_count),  64'(3));
    chk("sat_n_done", 64'(bus2.done_count), 64'(1));
    chk("sat_err",    64'(bus.err_count),   64'(5));
    chk("sat_resp",   64'(bus.rsp_resp),    64'(2));

    // cmd_valid held through the transaction, then spurious bvalid in IDLE
    do_reset();
    resp_q = '{2'b00, 2'b00};
    bus.cmd_addr = 32'h200; bus.cmd_data = 32'h5A5A5A5A; bus.cmd_strb = 4'hF;
    bus.cmd_valid = 1; accepts = 0;
    tick();
    first_acc = cyc;
    wait_rsp();
    chk("st_one_accept", 64'(accepts), 64'(1));
    tick();
    chk("st_reaccept",   64'(accepts), 64'(2));
    chk("st_turnaround", 64'(cyc - first_acc), 64'(3));
    bus.cmd_valid = 0;
    wait_rsp();
    spur_b = 1;
    repeat (3) tick();
    chk("sp_rsp",  64'(bus.rsp_valid),  64'(0));
    chk("sp_done", 64'(bus.done_count), 64'(2));
    chk("sp_err",  64'(bus.err_count),  64'(0));
    spur_b = 0;
    tick();

    // areset in RESP aborts without waiting for a clock edge
    b_lat = 4; resp_q = '{2'b10};
    send(32'h300, 32'hFEEDFACE, 4'hF);
    repeat (2) tick();
    chk("ar_bready_before", 64'(bus.bready), 64'(1));
    #2 areset = 1;
    #1;
    chk("ar_bready",  64'(bus.bready),     64'(0));
    chk("ar_busy",    64'(bus.busy),       64'(0));
    chk("ar_awaddr",  64'(bus.awaddr),     64'(0));
    chk("ar_done",    64'(bus.done_count), 64'(0));
    slave_clear();
    tick();
    areset = 0;
    tick();
    chk("ar_rsp_none", 64'(bus.rsp_valid), 64'(0));
    b_lat = 0; resp_q = '{2'b00};
    send(32'h304, 32'h0BADF00D, 4'hF);
    wait_rsp();
    chk("ar_after_done", 64'(bus.done_count), 64'(1));
    chk("ar_after_err",  64'(bus.err_count),  64'(0));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
